uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (115200 baud at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter BITS_N, default 8, number of data bits per frame.
REQ-003 SHALL have parameter PARITY_TYPE, default 0: 0 = none, 1 = odd, 2 = even; value 3 treated as none.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 data_tx  input  BITS_N  byte to transmit; sampled only at acceptance.
REQ-007 valid  input  1  request to transmit data_tx.
REQ-008 uart_out  output  1  serial line, idle high, registered.
REQ-009 ready  output  1  high when idle and able to accept a new word, registered.

Function
REQ-010 SHALL accept a word on any rising edge where valid=1 and ready=1, latching data_tx into an internal shift register.
REQ-011 SHALL ignore valid while ready=0; data_tx changes during a frame SHALL not affect the frame.
REQ-012 SHALL drive ready=0 from the cycle after acceptance until the frame ends.
REQ-013 SHALL drive the start bit (0) on uart_out beginning the cycle after acceptance.
REQ-014 Frame order: start(0), BITS_N data bits LSB first, parity bit (if PARITY_TYPE 1 or 2), one stop bit (1).
REQ-015 Each bit SHALL hold for exactly CLKS_PER_BIT cycles.
REQ-016 Even parity bit = XOR of data bits; odd parity bit = inverted XOR.
REQ-017 Frame length SHALL be (2 + BITS_N + parity_en) * CLKS_PER_BIT cycles; 11*434 = 4774 cycles for defaults with parity.
REQ-018 ready SHALL return to 1 in the cycle after the last stop-bit cycle, giving exactly one rising edge of ready per frame.
REQ-019 uart_out SHALL remain 1 whenever idle.
REQ-020 A new word accepted in the first idle cycle SHALL start with no extra gap beyond that cycle.
REQ-021 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-022 Transitions: IDLE->START on accept; START->DATA after CLKS_PER_BIT; DATA->PARITY or STOP after BITS_N bits; PARITY->STOP; STOP->IDLE.
REQ-023 Baud counter SHALL be sized $clog2(CLKS_PER_BIT) bits; bit index counter SHALL be sized $clog2(BITS_N+1) bits.
REQ-024 Both counters SHALL restart at 0 on every state change.

Reset
REQ-025 While rst=1: state=IDLE, uart_out=1, ready=1, counters=0, shift register=0.
REQ-026 rst asserted mid-frame SHALL abort the frame immediately; no partial bits after rst.
REQ-027 Clearing the shift register and counters alone does not abort the frame; the state reset of REQ-025 is required.
REQ-028 After rst deasserts, a word SHALL be accepted on the first rising edge with valid=1.

Structure
REQ-029 A shared package uart_pkg SHALL hold the state enum typedef and the PARITY_NONE, PARITY_ODD and PARITY_EVEN constants.
REQ-030 One sub-module, uart_baud_counter, SHALL generate the bit-period tick.
REQ-031 uart_baud_counter SHALL be parameterised by CLKS_PER_BIT and SHALL be cleared by the FSM on state change.
REQ-032 All other logic SHALL be inline.

Verification
REQ-033 Reset: hold rst 5 cycles -> uart_out=1, ready=1; assert rst mid-frame -> both return to 1 asynchronously.
REQ-034 Even parity, data 0xA5, one-cycle valid pulse -> uart_out sequence 0,1,0,1,0,0,1,0,1,0,1, each 434 cycles; ready low 4774 cycles, then single rising edge.
REQ-035 Even parity, data 0x01 -> parity bit 1; odd-parity instance, data 0x01 -> parity bit 0; PARITY_TYPE=0, data 0x01 -> 10-bit frame, 4340 cycles.
REQ-036 Valid pulsed while ready=0, data 0xFF -> ignored; current frame unchanged; no second frame.
REQ-037 Five random bytes, each sent 10 cycles after ready rises -> every frame decodes correctly with correct parity; total time well under 5*12*434*2 cycles.
REQ-038 Back-to-back: valid held high with 0x00 then 0xFF -> second start bit begins exactly one idle cycle after the first stop bit ends.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: tick_o is high on the last cycle of each CLKS_PER_BIT period.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, BITS_N data bits LSB first, optional parity, one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8,
  parameter int PARITY_TYPE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS_N-1:0] data_tx,
  input  logic              valid,
  output logic              uart_out,
  output logic              ready
);

  localparam bit PARITY_EN = (PARITY_TYPE == PARITY_ODD) || (PARITY_TYPE == PARITY_EVEN);
  localparam bit PARITY_INV = (PARITY_TYPE == PARITY_ODD);
  localparam int IDX_W = $clog2(BITS_N + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITS_N - 1);

  uart_state_e       state_q, state_d;
  logic [BITS_N-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              parity_q, parity_d;
  logic              out_q, out_d;
  logic              ready_q, ready_d;
  logic              tick;
  logic              state_chg;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_chg),
    .tick_o(tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    unique case (state_q)
      IDLE: begin
        if (valid && ready_q) begin
          state_d  = START;
          shift_d  = data_tx;
          parity_d = (^data_tx) ^ PARITY_INV;
        end
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    state_chg = (state_d != state_q);
    if (state_chg) begin
      idx_d = '0;
    end

    // Outputs are registered, so they are derived from the state being entered.
    unique case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = shift_d[0];
      PARITY:  out_d = parity_d;
      default: out_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      out_q    <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      out_q    <= out_d;
      ready_q  <= ready_d;
    end
  end

  assign uart_out = out_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench: five uart_tx instances (parity even/odd/none/3) against a frame-list model.
module tb_uart_tx;

  localparam int CF    = 5;
  localparam int LIMIT = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] valid_v = '0;
  logic [7:0] data_v [5];
  wire  [4:0] out_v;
  wire  [4:0] rdy_v;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx #(.CLKS_PER_BIT(434), .PARITY_TYPE(2)) u_i0 (
    .clk(clk), .rst(rst), .data_tx(data_v[0]), .valid(valid_v[0]), .uart_out(out_v[0]), .ready(rdy_v[0]));
  uart_tx #(.CLKS_PER_BIT(CF), .PARITY_TYPE(2)) u_i1 (
    .clk(clk), .rst(rst), .data_tx(data_v[1]), .valid(valid_v[1]), .uart_out(out_v[1]), .ready(rdy_v[1]));
  uart_tx #(.CLKS_PER_BIT(CF), .PARITY_TYPE(1)) u_i2 (
    .clk(clk), .rst(rst), .data_tx(data_v[2]), .valid(valid_v[2]), .uart_out(out_v[2]), .ready(rdy_v[2]));
  uart_tx #(.CLKS_PER_BIT(CF), .PARITY_TYPE(0)) u_i3 (
    .clk(clk), .rst(rst), .data_tx(data_v[3]), .valid(valid_v[3]), .uart_out(out_v[3]), .ready(rdy_v[3]));
  uart_tx #(.CLKS_PER_BIT(CF), .PARITY_TYPE(3)) u_i4 (
    .clk(clk), .rst(rst), .data_tx(data_v[4]), .valid(valid_v[4]), .uart_out(out_v[4]), .ready(rdy_v[4]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int clks_of(input int inst);
    return (inst == 0) ? 434 : CF;
  endfunction

  function automatic int ptype_of(input int inst);
    case (inst)
      0, 1:    return 2;
      2:       return 1;
      3:       return 0;
      default: return 3;
    endcase
  endfunction

  // Reference frame: list of line levels, one entry per bit period.
  task automatic build_frame(input logic [7:0] d, input int ptype,
                             output int nbits, output logic [15:0] bits);
    int ones = 0;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bits[1 + i] = d[i];
      ones += int'(d[i]);
    end
    nbits = 9;
    if (ptype == 1 || ptype == 2) begin
      bits[9] = (ptype == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      nbits = 10;
    end
    bits[nbits] = 1'b1;
    nbits++;
  endtask

  task automatic wait_ready(input int inst);
    int k = 0;
    while (rdy_v[inst] !== 1'b1 && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    if (k >= LIMIT) check_val($sformatf("i%0d_rdy_timeout", inst), 0, 1);
  endtask

  // Called at a negedge; returns at the negedge right after the frame should have ended.
  task automatic run_frame(input int inst, input logic [7:0] d, input bit inject,
                           input bit keep_valid, input logic [7:0] next_d);
    int          c, nbits, len, rdy_low, rises, hi;
    logic [15:0] bits;
    int          match [16];
    logic        prev;
    c = clks_of(inst);
    build_frame(d, ptype_of(inst), nbits, bits);
    len = nbits * c;
    for (int b = 0; b < 16; b++) match[b] = 0;
    wait_ready(inst);
    data_v[inst]  = d;
    valid_v[inst] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (keep_valid) data_v[inst] = next_d;
    else valid_v[inst] = 1'b0;
    rdy_low = 0;
    rises = 0;
    prev = 1'b1;
    for (int n = 0; n < len; n++) begin
      if (out_v[inst] === bits[n / c]) match[n / c]++;
      if (rdy_v[inst] === 1'b0) rdy_low++;
      if (rdy_v[inst] === 1'b1 && !prev) rises++;
      prev = rdy_v[inst];
      if (inject && n == len / 2) begin
        data_v[inst]  = 8'hFF;
        valid_v[inst] = 1'b1;
      end
      if (inject && n == len / 2 + 1) valid_v[inst] = 1'b0;
      @(negedge clk);
    end
    if (rdy_v[inst] === 1'b1 && !prev) rises++;
    for (int b = 0; b < nbits; b++)
      check_val($sformatf("i%0d_d%02h_bit%0d", inst, d, b), match[b], c);
    check_val($sformatf("i%0d_d%02h_rdy_low", inst, d), rdy_low, len);
    check_val($sformatf("i%0d_d%02h_rdy_rise", inst, d), rises, 1);
    check_val($sformatf("i%0d_d%02h_end_rdy", inst, d), rdy_v[inst], 1);
    check_val($sformatf("i%0d_d%02h_end_out", inst, d), out_v[inst], 1);
    $display("frame inst=%0d data=%02h bits=%0d cycles=%0d inject=%0d", inst, d, nbits, len, inject);
    if (inject) begin
      hi = 0;
      repeat (3 * c) begin
        if (out_v[inst] === 1'b1 && rdy_v[inst] === 1'b1) hi++;
        @(negedge clk);
      end
      check_val($sformatf("i%0d_no_second_frame", inst), hi, 3 * c);
    end
  endtask

  initial begin
    int          t0, hi;
    logic [7:0]  rd;
    for (int i = 0; i < 5; i++) data_v[i] = 8'h00;

    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_val("rst_out", out_v, 5'h1F);
    check_val("rst_rdy", rdy_v, 5'h1F);
    rst = 1'b0;

    run_frame(1, 8'h5A, 0, 0, 8'h00);
    run_frame(0, 8'hA5, 0, 0, 8'h00);

    for (int i = 1; i < 5; i++) run_frame(i, 8'h01, 0, 0, 8'h00);

    run_frame(1, 8'h3C, 1, 0, 8'h00);

    run_frame(1, 8'h00, 0, 1, 8'hFF);
    run_frame(1, 8'hFF, 0, 0, 8'h00);

    t0 = cyc;
    for (int k = 0; k < 5; k++) begin
      rd = 8'($urandom);
      run_frame(1, rd, 0, 0, 8'h00);
      repeat (10) @(negedge clk);
    end
    check_val("rand_total_time_ok", (cyc - t0) < 5 * 12 * CF * 2, 1);
    for (int i = 2; i < 5; i++) begin
      repeat (3) begin
        rd = 8'($urandom);
        run_frame(i, rd, 0, 0, 8'h00);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    wait_ready(1);
    data_v[1]  = 8'h00;
    valid_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_v[1] = 1'b0;
    @(negedge clk);
    check_val("pre_rst_out", out_v[1], 0);
    check_val("pre_rst_rdy", rdy_v[1], 0);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_out", out_v[1], 1);
    check_val("async_rst_rdy", rdy_v[1], 1);
    @(negedge clk);
    rst = 1'b0;
    hi = 0;
    repeat (2 * CF) begin
      if (out_v[1] === 1'b1 && rdy_v[1] === 1'b1) hi++;
      @(negedge clk);
    end
    check_val("post_rst_idle", hi, 2 * CF);
    run_frame(1, 8'hC3, 0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
